// File: rtl/axis_frame_slave_fifo.sv
// AXI-Stream video slave: SOF-aligned show-ahead FIFO with a per-line beat-count checker.
// Beats before the first tuser are discarded; afterwards every accepted beat is stored.
module axis_frame_slave_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LINE_BEATS = 640
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tuser,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last,
  output logic                         m_sof,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_count,
  output logic                         in_frame,
  output logic                         line_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(LINE_BEATS + 1);
  localparam int unsigned EW = DATA_WIDTH + 2;

  typedef enum logic {StWaitSof, StStream} state_e;

  state_e          r_state, w_state_next;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [EW-1:0]   w_head;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count, w_count_next;
  logic            r_tready, w_tready_next;
  logic [BW-1:0]   r_beat_cnt, w_beat_cnt_next, w_beat_inc;
  logic            r_line_err, w_line_err_next;
  logic            w_push, w_pop;

  // Non-SOF beats are accepted (tready stays high) but not written while waiting for SOF.
  assign w_push = s_axis_tvalid & r_tready & ((r_state == StStream) | s_axis_tuser);
  assign w_pop  = (r_count != '0) & m_ready;

  assign w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_tready_next = (w_count_next < CW'(DEPTH));
  assign w_beat_inc    = r_beat_cnt + 1'b1;

  always_comb begin
    w_state_next = r_state;
    if (r_state == StWaitSof && w_push) begin
      w_state_next = StStream;
    end
  end

  // Line checker: every written beat is in STREAM (the SOF write is the transition beat).
  always_comb begin
    w_beat_cnt_next = r_beat_cnt;
    w_line_err_next = 1'b0;
    if (w_push) begin
      if (s_axis_tuser) begin
        w_line_err_next = (r_beat_cnt != '0);
        w_beat_cnt_next = s_axis_tlast ? BW'(0) : BW'(1);
      end else if (s_axis_tlast) begin
        w_line_err_next = (w_beat_inc != BW'(LINE_BEATS));
        w_beat_cnt_next = '0;
      end else if (w_beat_inc == BW'(LINE_BEATS)) begin
        w_line_err_next = 1'b1;
        w_beat_cnt_next = '0;
      end else begin
        w_beat_cnt_next = w_beat_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StWaitSof;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_tready   <= 1'b0;
      r_beat_cnt <= '0;
      r_line_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_tready   <= w_tready_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_line_err <= w_line_err_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {s_axis_tdata, s_axis_tlast, s_axis_tuser};
    end
  end

  assign w_head        = r_mem[r_rptr];
  assign m_data        = w_head[EW-1:2];
  assign m_last        = w_head[1];
  assign m_sof         = w_head[0];
  assign m_valid       = (r_count != '0);
  assign fill_count    = r_count;
  assign s_axis_tready = r_tready;
  assign in_frame      = (r_state == StStream);
  assign line_err      = r_line_err;

endmodule

// File: tb/tb_axis_frame_slave_fifo.sv
// Directed bench for axis_frame_slave_fifo: a data scoreboard checked by a pop monitor,
// plus direct checks of occupancy, ready, frame state and line-error pulses.
module tb_axis_frame_slave_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LB    = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last, m_sof, m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] fill_count;
  logic          in_frame, line_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW+1:0] exp_q[$];
  bit frame_m = 1'b0;

  axis_frame_slave_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LINE_BEATS(LB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_data(m_data), .m_last(m_last), .m_sof(m_sof), .m_valid(m_valid), .m_ready(m_ready),
    .fill_count(fill_count), .in_frame(in_frame), .line_err(line_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A pop happens at the next rising edge; compare the head against the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 64'(m_data), 64'hDEAD);
      end else begin
        chk("pop_data", 64'({m_data, m_last, m_sof}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Offer one beat for one cycle; called #1 after an edge, returns #1 after the next edge.
  task automatic beat(input logic [DW-1:0] d, input logic l, input logic u, output logic acc);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    acc = s_axis_tready;
    @(posedge clk);
    if (acc && (frame_m || u)) begin
      exp_q.push_back({d, l, u});
      frame_m = 1'b1;
    end
    #1;
  endtask

  // exp_err < 0 means the line_err value is not checked for this beat.
  task automatic send(input logic [DW-1:0] d, input logic l, input logic u, input int exp_err);
    logic acc;
    beat(d, l, u, acc);
    chk("send_accepted", 64'(acc), 64'd1);
    if (exp_err >= 0) chk("line_err", 64'(line_err), 64'(exp_err));
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    s_axis_tvalid = 1'b0;
    m_ready = 1'b1;
    while (m_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(m_valid), 64'd0);
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    frame_m = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_fill", 64'(fill_count), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_in_frame", 64'(in_frame), 64'd0);
    chk("rst_line_err", 64'(line_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_rst", 64'(s_axis_tready), 64'd1);
  endtask

  initial begin
    logic acc;
    int   nxt;

    // SOF alignment: five stray beats dropped, then SOF 0xA5 stored.
    do_reset();
    for (int i = 0; i < 5; i++) send(32'h100 + 32'(i), 1'b0, 1'b0, 0);
    chk("pre_sof_fill", 64'(fill_count), 64'd0);
    chk("pre_sof_in_frame", 64'(in_frame), 64'd0);
    send(32'hA5, 1'b0, 1'b1, 0);
    chk("sof_fill", 64'(fill_count), 64'd1);
    chk("sof_m_data", 64'(m_data), 64'hA5);
    chk("sof_m_sof", 64'(m_sof), 64'd1);
    chk("sof_in_frame", 64'(in_frame), 64'd1);
    chk("sof_m_valid", 64'(m_valid), 64'd1);
    drain();

    // Fill to full with the consumer stalled; later offers must be refused.
    nxt = 0;
    for (int i = 0; i < 20; i++) begin
      beat(32'(nxt), 1'b0, 1'b0, acc);
      if (acc) begin
        nxt++;
        if (nxt == 16) chk("tready_drop_at_full", 64'(s_axis_tready), 64'd0);
      end
    end
    s_axis_tvalid = 1'b0;
    chk("full_accepted", 64'(nxt), 64'd16);
    chk("full_fill", 64'(fill_count), 64'd16);
    chk("full_tready", 64'(s_axis_tready), 64'd0);
    chk("full_head", 64'(m_data), 64'd0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_pop", 64'(s_axis_tready), 64'd1);
    chk("fill_after_pop", 64'(fill_count), 64'd15);
    drain();

    // Steady push+pop at occupancy 3; pointers wrap several times.
    for (int i = 0; i < 3; i++) send(32'h200 + 32'(i), 1'b0, 1'b0, -1);
    chk("steady_fill_start", 64'(fill_count), 64'd3);
    m_ready = 1'b1;
    for (int i = 3; i < 103; i++) begin
      beat(32'h200 + 32'(i), 1'b0, 1'b0, acc);
      chk("steady_accept", 64'(acc), 64'd1);
      chk("steady_fill", 64'(fill_count), 64'd3);
    end
    drain();

    // Line checker, consumer free-running.
    do_reset();
    m_ready = 1'b1;
    send(32'h300, 1'b0, 1'b1, 0);
    send(32'h301, 1'b0, 1'b0, 0);
    send(32'h302, 1'b1, 1'b0, 1);           // tlast on 3rd beat: short line
    idle(1);
    chk("err_one_cycle", 64'(line_err), 64'd0);
    send(32'h310, 1'b0, 1'b0, 0);
    send(32'h311, 1'b0, 1'b0, 0);
    send(32'h312, 1'b0, 1'b0, 0);
    send(32'h313, 1'b1, 1'b0, 0);           // correct 4-beat line
    send(32'h320, 1'b0, 1'b0, 0);
    send(32'h321, 1'b0, 1'b0, 0);
    send(32'h322, 1'b0, 1'b0, 0);
    send(32'h323, 1'b0, 1'b0, 1);           // 4th beat without tlast
    send(32'h324, 1'b0, 1'b0, 0);
    send(32'h330, 1'b0, 1'b1, 1);           // SOF mid-line
    send(32'h331, 1'b0, 1'b0, 0);
    send(32'h332, 1'b0, 1'b0, 0);
    send(32'h333, 1'b1, 1'b0, 0);           // count restarted at 1: line is exact
    drain();

    // Reset mid-frame with 7 beats buffered.
    for (int i = 0; i < 7; i++) send(32'h400 + 32'(i), 1'b0, 1'b0, -1);
    chk("pre_rst_fill", 64'(fill_count), 64'd7);
    do_reset();
    send(32'h500, 1'b0, 1'b0, 0);
    send(32'h501, 1'b1, 1'b0, 0);
    chk("post_rst_dropped", 64'(fill_count), 64'd0);
    chk("post_rst_in_frame", 64'(in_frame), 64'd0);
    send(32'h77, 1'b0, 1'b1, 0);
    chk("post_rst_sof_fill", 64'(fill_count), 64'd1);
    chk("post_rst_sof_data", 64'(m_data), 64'h77);
    drain();
    idle(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_frame_slave_fifo.md
# axis_frame_slave_fifo

Parametrised AXI-Stream video slave that replaces the single-register receiver at the pixel-input boundary. It buffers accepted beats in a DEPTH-entry FIFO and aligns to start-of-frame (tuser), discarding beats until the first SOF. It also checks every line against a fixed beat count. Downstream logic (memory writer, processing pipeline) pops beats through a show-ahead valid/ready port.

## Interface
- DATA_WIDTH, 32, width of tdata and of each FIFO entry
- DEPTH, 16, number of FIFO entries; power of 2, ≥ 2
- LINE_BEATS, 640, expected beats per line, from first beat of a line to its tlast beat inclusive; ≥ 2
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- s_axis_tdata  input  DATA_WIDTH  pixel data
- s_axis_tvalid  input  1  source has a beat
- s_axis_tready  output  1  block accepts a beat (registered)
- s_axis_tlast  input  1  end of line
- s_axis_tuser  input  1  start of frame
- m_data  output  DATA_WIDTH  head-of-FIFO data
- m_last  output  1  head beat's tlast
- m_sof  output  1  head beat's tuser
- m_valid  output  1  FIFO not empty
- m_ready  input  1  consumer pops head when m_valid=1
- fill_count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- in_frame  output  1  high in STREAM state
- line_err  output  1  one-cycle pulse on line-length violation

## Operation
- Handshake: a beat transfers on a rising edge with s_axis_tvalid & s_axis_tready. A pop occurs on a rising edge with m_valid & m_ready.
- States: WAIT_SOF (reset state) and STREAM.
- WAIT_SOF: accepted beats with tuser=0 are dropped, not written. An accepted beat with tuser=1 is written, and the state moves to STREAM.
- STREAM: every accepted beat is written with its {tdata, tlast, tuser}. Stays in STREAM until reset; no other exit.
- FIFO storage: register array, write/read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Show-ahead output: m_data, m_last and m_sof reflect the entry at the read pointer. They are don't-care when m_valid=0 and must be stable while m_valid=1 and m_ready=0.
- Line checker (STREAM only, counts written beats; beat_cnt is 0..LINE_BEATS):
  - beat with tuser=1 (incl. the SOF that enters STREAM): if beat_cnt≠0, pulse line_err. Then beat_cnt=1, or 0 if this beat also has tlast.
  - beat with tlast=1 and tuser=0: if beat_cnt+1≠LINE_BEATS, pulse line_err. Then beat_cnt=0.
  - other beats: beat_cnt+1. If this reaches LINE_BEATS (missing tlast), pulse line_err and beat_cnt=0.
  - Errored beats are still stored. The checker never stalls or drops data.

## Timing
- Reset values (asynchronous): s_axis_tready=0, m_valid=0, fill_count=0, in_frame=0, line_err=0, pointers=0, beat_cnt=0, state=WAIT_SOF.
- s_axis_tready is a register.
  - Next value = (next fill_count < DEPTH).
  - Rises on the first clk edge after rst_n deasserts.
  - Drops on the same edge at which the FIFO becomes full.
  - Never high while fill_count=DEPTH.
  - A pop while full re-asserts ready one cycle later. There is no write-through at full.
- Latency: a beat written at edge k gives m_valid=1 and the correct head in cycle k+1 (fill_count updated at k). Empty FIFO: no bypass, so minimum latency is 1 cycle.
- line_err goes high in the cycle after the offending beat's edge, for exactly one cycle.
- in_frame goes high in the cycle after the SOF beat's edge.
- Reset asserted mid-operation: all contents are discarded, and all outputs return to reset values immediately.

## Test plan
- Reset, then 5 beats with tuser=0 followed by an SOF beat 0xA5: the first 5 are dropped, and fill_count=1, m_data=0xA5, m_sof=1, in_frame=1 after the SOF edge.
- DEPTH=16 with m_ready=0, push 20 beats continuously: 16 are accepted, s_axis_tready=0 from the cycle after the 16th write, fill_count=16. Then raise m_ready: order 0..15 is preserved and ready returns 1 cycle after the first pop.
- Continuous push and pop at fill_count=3 for 100 cycles: fill_count stays 3, data in-order, and pointers wrap cleanly.
- LINE_BEATS=4, after SOF send a tlast on the 3rd beat: line_err pulses once. Then a correct 4-beat line: no pulse.
- LINE_BEATS=4, 5 beats with no tlast: line_err pulses after the 4th beat. A tuser beat arriving mid-line: line_err pulses and beat_cnt restarts at 1.
- Assert rst_n low with fill_count=7 mid-frame: the same cycle shows m_valid=0, fill_count=0, tready=0, in_frame=0. After release, beats are dropped until the next SOF.
